// File: rtl/imem_pkg.sv
// imem_pkg: shared types and constants for the instruction-memory responder.
// Holds the responder state encoding, the default response latency and the
// word returned for misaligned fetches.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int          DEFAULT_LATENCY = 4;
    localparam logic [15:0] NOP_WORD        = 16'h0000;

    // Byte address of the next sequential instruction (wraps at 16 bits).
    function automatic logic [15:0] next_line(input logic [15:0] a);
        return a + 16'd2;
    endfunction

endpackage

// File: rtl/imem_array.sv
// imem_array: 2^DEPTH_LOG2 x 16-bit program storage.
// Synchronous write, combinational (asynchronous) read, so a read of a word
// being written in the same cycle returns the old contents.
module imem_array #(
    parameter int DEPTH_LOG2 = 15
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [DEPTH_LOG2-1:0] i_wr_idx,
    input  logic [15:0]           i_wr_data,
    input  logic [DEPTH_LOG2-1:0] i_rd_idx,
    output logic [15:0]           o_rd_data
);

    logic [15:0] r_mem [0:(1<<DEPTH_LOG2)-1];

    // Program-load write port.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/imem_responder.sv
// imem_responder: fetch-side instruction memory with a fixed response latency.
// Accepts one byte-address request at a time, returns the 16-bit word (or an
// error for odd addresses) LATENCY cycles later as a one-cycle rsp_valid pulse.
// Optional build macro IMEM_PREFETCH_EN adds a one-entry next-line buffer that
// answers sequential fetches with latency 1.
module imem_responder
    import imem_pkg::*;
#(
    parameter int LATENCY    = DEFAULT_LATENCY,
    parameter int DEPTH_LOG2 = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [15:0] req_addr,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    input  logic        wr_en,
    input  logic [15:0] wr_addr,
    input  logic [15:0] wr_data
);

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [15:0] r_rsp_data;
    logic        r_rsp_err;
    logic [15:0] r_word;
    logic        r_err_p;

    logic                  w_accept;
    logic                  w_aligned;
    logic                  w_hit;
    logic [15:0]           w_hit_data;
    logic [15:0]           w_acc_word;
    logic [DEPTH_LOG2-1:0] w_req_idx;
    logic [DEPTH_LOG2-1:0] w_wr_idx;
    logic [DEPTH_LOG2-1:0] w_rd_idx;
    logic [15:0]           w_rd_data;
    logic                  w_unused;

    assign w_accept   = req_valid && r_req_ready;
    assign w_aligned  = ~req_addr[0];
    assign w_req_idx  = req_addr[DEPTH_LOG2:1];
    assign w_wr_idx   = wr_addr[DEPTH_LOG2:1];
    assign w_acc_word = w_aligned ? w_rd_data : NOP_WORD;
    // Address bits above the word index and wr_addr[0] are deliberately ignored.
    assign w_unused   = ^{req_addr, wr_addr};

    imem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk       (clk),
        .i_wr_en   (wr_en),
        .i_wr_idx  (w_wr_idx),
        .i_wr_data (wr_data),
        .i_rd_idx  (w_rd_idx),
        .o_rd_data (w_rd_data)
    );

`ifdef IMEM_PREFETCH_EN
    logic [15:0]           r_addr;
    logic [15:0]           r_pf_tag;
    logic [15:0]           r_pf_data;
    logic                  r_pf_vld;
    logic [15:0]           w_refill_addr;
    logic [DEPTH_LOG2-1:0] w_refill_idx;
    logic                  w_tag_wr;

    assign w_refill_addr = next_line(r_addr);
    assign w_refill_idx  = w_refill_addr[DEPTH_LOG2:1];
    // The single read port serves the fetch in IDLE and the refill in RESP.
    assign w_rd_idx      = (r_state == RESP) ? w_refill_idx : w_req_idx;
    assign w_tag_wr      = wr_en && (w_wr_idx == r_pf_tag[DEPTH_LOG2:1]);
    // A write to the buffered word in the same cycle forces a miss.
    assign w_hit         = w_aligned && r_pf_vld && (req_addr == r_pf_tag) && !w_tag_wr;
    assign w_hit_data    = r_pf_data;

    // Next-line buffer: refill after each aligned response, drop on overlapping writes.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr <= req_addr;
        end
        if (rst) begin
            r_pf_vld <= 1'b0;
        end else if ((r_state == RESP) && !r_err_p) begin
            r_pf_tag  <= w_refill_addr;
            r_pf_data <= w_rd_data;
            r_pf_vld  <= !(wr_en && (w_wr_idx == w_refill_idx));
        end else if (w_tag_wr) begin
            r_pf_vld <= 1'b0;
        end
    end
`else
    assign w_rd_idx   = w_req_idx;
    assign w_hit      = 1'b0;
    assign w_hit_data = NOP_WORD;
`endif

    // Capture the word and error flag at accept; they are presented on RESP entry.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_word  <= w_acc_word;
            r_err_p <= ~w_aligned;
        end
    end

    // Responder FSM with registered handshake and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= NOP_WORD;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        if (w_hit) begin
                            r_state     <= RESP;
                            r_cnt       <= 4'd0;
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= w_hit_data;
                            r_rsp_err   <= 1'b0;
                        end else if (LATENCY == 1) begin
                            r_state     <= RESP;
                            r_cnt       <= 4'd0;
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= w_acc_word;
                            r_rsp_err   <= ~w_aligned;
                        end else begin
                            r_state <= BUSY;
                            r_cnt   <= CNT_LOAD;
                        end
                    end
                end
                BUSY: begin
                    if (r_cnt <= 4'd1) begin
                        r_state     <= RESP;
                        r_cnt       <= 4'd0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= r_word;
                        r_rsp_err   <= r_err_p;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    r_state     <= IDLE;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state     <= IDLE;
                    r_cnt       <= 4'd0;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: randomized bench for imem_responder with a behavioural
// memory / next-line-buffer model. Compile with IMEM_PREFETCH_EN to match a
// DUT built with the prefetch buffer.
module tb_imem_responder;

    localparam int LAT = 4;
`ifdef IMEM_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [15:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [15:0] mdl_mem [0:32767];
    logic [15:0] pf_tag;
    logic [15:0] pf_data;
    bit          pf_vld;
    logic [15:0] last_data;

    imem_responder #(
        .LATENCY    (LAT),
        .DEPTH_LOG2 (15)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit in_region(input logic [15:0] a);
        return (a < 16'h0200) || (a >= 16'hFFF0);
    endfunction

    task automatic mdl_wr(input logic [15:0] a, input logic [15:0] d);
        mdl_mem[a[15:1]] = d;
        if (pf_vld && (a[15:1] == pf_tag[15:1])) pf_vld = 1'b0;
    endtask

    // Predict one accepted request: hit / data / err, then apply its side effects.
    task automatic mdl_req(input logic [15:0] a, input bit same_wr, input logic [15:0] wd,
                           output bit hit, output logic [15:0] data, output bit err);
        logic [15:0] nxt;
        err  = a[0];
        hit  = PF && pf_vld && !a[0] && (a == pf_tag) &&
               !(same_wr && (a[15:1] == pf_tag[15:1]));
        data = err ? 16'h0000 : (hit ? pf_data : mdl_mem[a[15:1]]);
        if (same_wr) mdl_wr(a, wd);
        if (PF && !err) begin
            nxt     = a + 16'd2;
            pf_tag  = nxt;
            pf_data = mdl_mem[nxt[15:1]];
            pf_vld  = 1'b1;
        end
    endtask

    // Called at a negedge while idle; one write per cycle.
    task automatic do_write(input logic [15:0] a, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        mdl_wr(a, d);
    endtask

    // Called at a negedge while idle; issues one request and checks the whole
    // handshake through the cycle after ready returns.
    task automatic fetch(input logic [15:0] a, input bit same_wr, input logic [15:0] wd);
        bit          hit;
        bit          err;
        logic [15:0] data;
        int          lat;
        check_eq("idle_ready", req_ready, 1);
        mdl_req(a, same_wr, wd, hit, data, err);
        lat       = hit ? 1 : LAT;
        req_valid = 1'b1;
        req_addr  = a;
        if (same_wr) begin
            wr_en   = 1'b1;
            wr_addr = a;
            wr_data = wd;
        end
        @(negedge clk);
        req_valid = 1'b0;
        wr_en     = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            check_eq("busy_ready", req_ready, 0);
            check_eq("rsp_valid", rsp_valid, 32'(k == lat));
            if (k == lat) begin
                check_eq("rsp_data", rsp_data, data);
                check_eq("rsp_err", rsp_err, err);
            end else begin
                check_eq("hold_data", rsp_data, last_data);
            end
            @(negedge clk);
        end
        last_data = data;
        check_eq("ready_back", req_ready, 1);
        check_eq("valid_drop", rsp_valid, 0);
        check_eq("data_hold", rsp_data, last_data);
    endtask

    function automatic logic [15:0] rand_addr(input logic [15:0] prev);
        logic [15:0] a;
        logic [15:0] nxt;
        nxt = prev + 16'd2;
        if (($urandom_range(0, 9) < 4) && !prev[0] && in_region(nxt))
            a = nxt;
        else if ($urandom_range(0, 7) == 0)
            a = 16'hFFF0 + 16'(2 * $urandom_range(0, 7));
        else
            a = 16'(2 * $urandom_range(0, 255));
        if ($urandom_range(0, 3) == 0) a[0] = 1'b1;
        return a;
    endfunction

    task automatic throughput_test();
        int          acc_cyc [3];
        int          lat_q   [3];
        logic [15:0] exp_q   [3];
        int          k;
        int          rsp_cnt;
        bit          acc_now;
        bit          hit;
        bit          err;
        logic [15:0] data;
        k         = 0;
        rsp_cnt   = 0;
        req_valid = 1'b1;
        req_addr  = 16'h0000;
        for (int cyc = 0; cyc < 100 && (k < 3 || rsp_cnt < 3); cyc++) begin
            if (rsp_valid) begin
                if (rsp_cnt < 3) check_eq("thru_data", rsp_data, exp_q[rsp_cnt]);
                rsp_cnt++;
            end
            acc_now = req_ready && req_valid;
            if (acc_now) begin
                mdl_req(req_addr, 1'b0, 16'h0000, hit, data, err);
                acc_cyc[k] = cyc;
                lat_q[k]   = hit ? 1 : LAT;
                exp_q[k]   = data;
                last_data  = data;
            end
            @(posedge clk);
            if (acc_now) k++;
            @(negedge clk);
            req_valid = (k < 3);
            req_addr  = 16'(2 * k);
        end
        req_valid = 1'b0;
        check_eq("thru_accepts", k, 3);
        check_eq("thru_rsps", rsp_cnt, 3);
        if (k == 3) begin
            check_eq("thru_gap0", acc_cyc[1] - acc_cyc[0], lat_q[0] + 1);
            check_eq("thru_gap1", acc_cyc[2] - acc_cyc[1], lat_q[1] + 1);
        end
        @(negedge clk);
    endtask

    task automatic reset_midop_test();
        check_eq("rst_pre_ready", req_ready, 1);
        req_valid = 1'b1;
        req_addr  = 16'h0010;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        pf_vld    = 1'b0;
        last_data = 16'h0000;
        check_eq("rst_ready", req_ready, 1);
        check_eq("rst_valid", rsp_valid, 0);
        check_eq("rst_data", rsp_data, 16'h0000);
        check_eq("rst_err", rsp_err, 0);
        for (int i = 0; i < LAT + 2; i++) begin
            check_eq("rst_no_rsp", rsp_valid, 0);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [15:0] prev;
        logic [15:0] a;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = 16'h0000;
        wr_en     = 1'b0;
        wr_addr   = 16'h0000;
        wr_data   = 16'h0000;
        pf_vld    = 1'b0;
        pf_tag    = 16'h0000;
        pf_data   = 16'h0000;
        last_data = 16'h0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check_eq("reset_ready", req_ready, 1);
        check_eq("reset_valid", rsp_valid, 0);
        check_eq("reset_data", rsp_data, 16'h0000);
        check_eq("reset_err", rsp_err, 0);

        for (int i = 0; i < 256; i++) do_write(16'(2 * i), 16'($urandom));
        for (int i = 0; i < 8; i++) do_write(16'hFFF0 + 16'(2 * i), 16'($urandom));
        do_write(16'h0010, 16'hA5A5);
        do_write(16'h0020, 16'h0000);

        fetch(16'h0010, 1'b0, 16'h0000);
        fetch(16'h0011, 1'b0, 16'h0000);
        throughput_test();
        reset_midop_test();
        fetch(16'h0020, 1'b1, 16'h1234);
        fetch(16'h0020, 1'b0, 16'h0000);

        fetch(16'h0100, 1'b0, 16'h0000);
        fetch(16'h0102, 1'b0, 16'h0000);
        fetch(16'h0100, 1'b0, 16'h0000);
        do_write(16'h0102, 16'h5A5A);
        fetch(16'h0102, 1'b0, 16'h0000);
        fetch(16'hFFFE, 1'b0, 16'h0000);
        fetch(16'h0000, 1'b0, 16'h0000);

        prev = 16'h0000;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                a = prev + 16'd2;
                if (!in_region(a) || $urandom_range(0, 1) == 0) a = 16'(2 * $urandom_range(0, 255));
                do_write(a, 16'($urandom));
            end
            a = rand_addr(prev);
            fetch(a, ($urandom_range(0, 5) == 0), 16'($urandom));
            prev = a;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder sitting on the fetch side of the program counter. It accepts byte addresses issued by the PC and returns one 16-bit instruction word per request after a fixed, parameterised latency. A side write port loads the program. The block models the multi-cycle instruction memory that the fetch stage stalls on.

## Interface
Parameters:
- LATENCY, 4, cycles from accept to response; legal range 1..15
- DEPTH_LOG2, 15, log2 of word count; word index = req_addr[DEPTH_LOG2:1]

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  fetch request present
- req_addr  in  16  byte address (PC value)
- req_ready  out  1  block can accept a request this cycle
- rsp_valid  out  1  one-cycle pulse: rsp_data/rsp_err valid
- rsp_data  out  16  instruction word
- rsp_err  out  1  misaligned request (req_addr[0]=1)
- wr_en  in  1  program-load write strobe
- wr_addr  in  16  byte address of write; bit 0 ignored
- wr_data  in  16  word to write

## Operation
- FSM states: IDLE, BUSY, RESP. Reset → IDLE.
- IDLE: req_ready=1. Accept when req_valid&&req_ready at an edge: latch address, read array word that cycle (read-old on same-cycle write to same word), load counter = LATENCY-1, go BUSY (LATENCY=1: go straight to RESP).
- BUSY: req_ready=0; decrement counter; at 0 → RESP.
- RESP: rsp_valid=1, req_ready=0 for exactly one cycle, then IDLE.
- Misaligned (req_addr[0]=1): same latency, rsp_err=1, rsp_data=16'h0000.
- rsp_data/rsp_err hold last value outside RESP; consumers qualify with rsp_valid.
- Writes: performed any state, visible next cycle. Never stall requests.
- Address wrap: word index uses low DEPTH_LOG2 bits only; upper bits ignored.

## Timing
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_data=16'h0000, rsp_err=0, counter=0, prefetch buffer invalid.
- Accept at edge E0 → rsp_valid high in cycle after edge E0+LATENCY-1; req_ready returns high after edge E0+LATENCY.
- Max throughput: one request per LATENCY+1 cycles.
- Reset mid-operation: request aborted, no rsp_valid issued.
- req_valid while req_ready=0: ignored; requester must hold.

## Configuration
- IMEM_PREFETCH_EN defined: one-entry next-line buffer (tag, data, valid). In the RESP cycle of an aligned request the buffer loads mem[addr+2] (16-bit wrap, 16'hFFFE → 16'h0000), valid=1. An accepted aligned request with addr==tag and valid skips BUSY: RESP in the cycle after accept (latency 1), then buffer refills from new addr+2. A wr_en whose word index matches tag clears valid that cycle; a same-cycle hit on that tag is treated as a miss. Misaligned requests never hit and never refill.
- Undefined: no buffer; every request takes LATENCY.

## Structure
- Package imem_pkg: state enum (IDLE, BUSY, RESP), default LATENCY, NOP word constant 16'h0000.
- Sub-module imem_array: 2^DEPTH_LOG2 x 16 storage, synchronous write, combinational read; responder FSM, counter and prefetch buffer in the top.

## Test plan
- Reset, write 16'hA5A5 to 0x0010, request 0x0010 at edge E0 (LATENCY=4) → rsp_valid only in cycle after E0+3, rsp_data=16'hA5A5, rsp_err=0, req_ready low E0..E0+4.
- Request 0x0011 → rsp_err=1, rsp_data=16'h0000, same latency.
- req_valid held high continuously with addresses 0,2,4 → accepts spaced 5 cycles, three responses, none dropped.
- Assert rst two cycles after accept → no rsp_valid, req_ready=1 after reset edge.
- Same-cycle wr_en 0x0020←16'h1234 (old 16'h0000) and accept 0x0020 → response 16'h0000; next request 0x0020 → 16'h1234.
- IMEM_PREFETCH_EN: fetch 0x0100 then 0x0102 → second response latency 1; repeat with write to 0x0102 between → full LATENCY, new data returned; fetch 0xFFFE then 0x0000 → hit.
